// File: rtl/gaussian_nb_mac_pkg.sv
// Shared definitions for the Gaussian naive-Bayes multiply-accumulate pipe.
package gaussian_nb_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Per-beat control that travels alongside the operands.
    typedef struct packed {
        logic last;
        logic first;
        logic mode;
    } beat_flags_t;

    localparam int unsigned FLAGS_W = $bits(beat_flags_t);

    // Largest value representable in a w-bit two's complement word.
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's complement word.
    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/gaussian_nb_mac_mul.sv
// STAGES-deep signed multiplier with a parallel valid/flag shift register.
// Data path carries no reset so it maps onto DSP pipeline registers.
module gaussian_nb_mac_mul
    import gaussian_nb_mac_pkg::*;
#(
    parameter int unsigned A_W    = 16,
    parameter int unsigned B_W    = 23,
    parameter int unsigned STAGES = 3,
    parameter int unsigned FLG_W  = FLAGS_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic signed [A_W-1:0]      in_a,
    input  logic signed [B_W-1:0]      in_b,
    input  logic [FLG_W-1:0]           in_flags,
    output logic                       out_valid,
    output logic signed [A_W+B_W-1:0]  out_p,
    output logic [FLG_W-1:0]           out_flags
);

    localparam int unsigned P_W = A_W + B_W;

    logic signed [A_W-1:0]           r_a;
    logic signed [B_W-1:0]           r_b;
    logic signed [P_W-1:0]           r_p [STAGES-1];
    logic [STAGES-1:0]               r_vld;
    logic [STAGES-1:0][FLG_W-1:0]    r_flg;

    // Operand register, product register and extra product delay stages.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_p[0] <= r_a * r_b;
            for (int unsigned i = 1; i < STAGES - 1; i++) begin
                r_p[i] <= r_p[i-1];
            end
            r_flg  <= {r_flg[STAGES-2:0], in_flags};
        end
    end

    // Valid tags follow the data; these are the only reset registers here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
        end else if (ce) begin
            r_vld <= {r_vld[STAGES-2:0], in_valid};
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign out_p     = r_p[STAGES-2];
    assign out_flags = r_flg[STAGES-1];

endmodule

// File: rtl/gaussian_nb_mac_pipe.sv
// Pipelined signed MAC: multiplier, framed accumulator with sticky overflow,
// and a round-half-up / saturate output stage.
module gaussian_nb_mac_pipe
    import gaussian_nb_mac_pkg::*;
#(
    parameter int unsigned A_W        = 16,
    parameter int unsigned B_W        = 23,
    parameter int unsigned MUL_STAGES = 3,
    parameter int unsigned ACC_W      = 48,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic                     in_valid,
    input  logic signed [A_W-1:0]    in_a,
    input  logic signed [B_W-1:0]    in_b,
    input  logic                     in_acc,
    input  logic                     in_first,
    input  logic                     in_last,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     out_ovf
);

    localparam int unsigned P_W = A_W + B_W;
    // Half an output LSB; zero when no shift is applied.
    localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((64'd1 << SHIFT) >> 1);

    beat_flags_t              w_in_flg;
    beat_flags_t              w_p_flg;
    logic [FLAGS_W-1:0]       w_p_flg_raw;
    logic                     w_p_vld;
    logic signed [P_W-1:0]    w_p;
    logic signed [ACC_W-1:0]  w_p_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_wrap;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic                     w_ovf_nxt;
    logic                     w_emit;
    logic signed [ACC_W:0]    w_rnd;
    logic signed [ACC_W:0]    w_shr;
    logic signed [63:0]       w_shr64;
    logic                     w_hi;
    logic                     w_lo;
    logic signed [OUT_W-1:0]  w_res;

    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_ovf;
    logic                     r_emit;

    assign w_in_flg = '{last: in_last, first: in_first, mode: in_acc};

    gaussian_nb_mac_mul #(
        .A_W    (A_W),
        .B_W    (B_W),
        .STAGES (MUL_STAGES),
        .FLG_W  (FLAGS_W)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_flags  (w_in_flg),
        .out_valid (w_p_vld),
        .out_p     (w_p),
        .out_flags (w_p_flg_raw)
    );

    assign w_p_flg = beat_flags_t'(w_p_flg_raw);
    assign w_p_ext = ACC_W'(w_p);
    assign w_sum   = r_acc + w_p_ext;
    assign w_wrap  = (r_acc[ACC_W-1] == w_p_ext[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    // Accumulator next state: multiply and first beats load, others add.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        w_emit    = 1'b0;
        if (w_p_vld) begin
            if (w_p_flg.mode == MODE_MUL) begin
                w_acc_nxt = w_p_ext;
                w_ovf_nxt = 1'b0;
                w_emit    = 1'b1;
            end else if (w_p_flg.first) begin
                w_acc_nxt = w_p_ext;
                w_ovf_nxt = 1'b0;
                w_emit    = w_p_flg.last;
            end else begin
                w_acc_nxt = w_sum;
                w_ovf_nxt = r_ovf | w_wrap;
                w_emit    = w_p_flg.last;
            end
        end
    end

    // Accumulator, sticky overflow and emit tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc  <= '0;
            r_ovf  <= 1'b0;
            r_emit <= 1'b0;
        end else if (ce) begin
            r_acc  <= w_acc_nxt;
            r_ovf  <= w_ovf_nxt;
            r_emit <= w_emit;
        end
    end

    // Round half toward +inf at ACC_W+1 bits, shift, then clip to OUT_W.
    always_comb begin
        w_rnd   = $signed({r_acc[ACC_W-1], r_acc}) + RND;
        w_shr   = w_rnd >>> SHIFT;
        w_shr64 = 64'(w_shr);
        w_hi    = w_shr64 > sat_max(OUT_W);
        w_lo    = w_shr64 < sat_min(OUT_W);
        w_res   = w_shr64[OUT_W-1:0];
        if (w_hi) begin
            w_res = OUT_W'(sat_max(OUT_W));
        end else if (w_lo) begin
            w_res = OUT_W'(sat_min(OUT_W));
        end
    end

    // Output register: pulse valid, hold data between emitted results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            out_valid <= r_emit;
            if (r_emit) begin
                out_data <= w_res;
                out_sat  <= w_hi | w_lo;
                out_ovf  <= r_ovf;
            end
        end
    end

endmodule

// File: tb/tb_gaussian_nb_mac_pipe.sv
module tb_gaussian_nb_mac_pipe;

    logic clk = 1'b0;
    logic reset_n;
    logic ce;
    logic in_valid;
    logic signed [15:0] in_a;
    logic signed [22:0] in_b;
    logic in_acc;
    logic in_first;
    logic in_last;

    logic               out_valid,  s4_valid;
    logic signed [31:0] out_data,   s4_data;
    logic               out_sat,    s4_sat;
    logic               out_ovf,    s4_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gaussian_nb_mac_pipe u_dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_first(in_first),
        .in_last(in_last), .out_valid(out_valid), .out_data(out_data),
        .out_sat(out_sat), .out_ovf(out_ovf)
    );

    gaussian_nb_mac_pipe #(.SHIFT(4)) u_dut_s4 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .in_valid(in_valid),
        .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_first(in_first),
        .in_last(in_last), .out_valid(s4_valid), .out_data(s4_data),
        .out_sat(s4_sat), .out_ovf(s4_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input int a, input int b,
                        input logic acc, input logic f, input logic l);
        in_valid = v;
        in_a     = 16'(a);
        in_b     = 23'(b);
        in_acc   = acc;
        in_first = f;
        in_last  = l;
    endtask

    task automatic idle();
        beat(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ce = 1'b1;
        idle();
        step(); step(); step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'sd0 || out_sat !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%0d s=%b o=%b expected 0 0 0 0", out_valid, out_data, out_sat, out_ovf);
        end
        checks++;
        if (s4_valid !== 1'b0 || s4_data !== 32'sd0) begin
            errors++;
            $display("FAIL reset_state_s4: got v=%b d=%0d expected 0 0", s4_valid, s4_data);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_multiply();
        beat(1'b1, 3, -5, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (out_valid !== (k == 5)) begin
                errors++;
                $display("FAIL mul_valid k=%0d: got %b expected %b", k, out_valid, (k == 5));
            end
            if (k >= 5) begin
                checks++;
                if (out_data !== 32'(-15) || out_sat !== 1'b0 || out_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_data k=%0d: got %0d sat=%b ovf=%b expected -15 0 0", k, out_data, out_sat, out_ovf);
                end
            end
            if (k < 6) step();
        end
    endtask

    task automatic test_accumulate();
        beat(1'b1, 2, 3, 1'b1, 1'b1, 1'b0);
        step();
        beat(1'b1, 4, 5, 1'b1, 1'b0, 1'b0);
        step();
        beat(1'b1, -1, 6, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (out_valid !== (k == 5)) begin
                errors++;
                $display("FAIL acc_valid k=%0d: got %b expected %b", k, out_valid, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (out_data !== 32'sd20 || out_sat !== 1'b0 || out_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL acc_data: got %0d sat=%b ovf=%b expected 20 0 0", out_data, out_sat, out_ovf);
                end
                checks++;
                if (s4_data !== 32'sd1) begin
                    errors++;
                    $display("FAIL acc_data_s4: got %0d expected 1", s4_data);
                end
            end
            if (k < 6) step();
        end
    endtask

    task automatic test_saturation();
        beat(1'b1, -32768, -4194304, 1'b0, 1'b0, 1'b0);
        step();
        beat(1'b1, -32768, 4194303, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        for (int j = 2; j <= 7; j++) begin
            if (j == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'sh7fffffff || out_sat !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pos: got v=%b d=%0d s=%b expected 1 2147483647 1", out_valid, out_data, out_sat);
                end
                checks++;
                if (s4_data !== 32'sh7fffffff || s4_sat !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pos_s4: got d=%0d s=%b expected 2147483647 1", s4_data, s4_sat);
                end
            end
            if (j >= 6) begin
                checks++;
                if (out_valid !== (j == 6) || out_data !== 32'sh80000000 || out_sat !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_neg j=%0d: got v=%b d=%0d s=%b expected %b -2147483648 1", j, out_valid, out_data, out_sat, (j == 6));
                end
            end
            if (j < 7) step();
        end
    endtask

    task automatic test_rounding();
        beat(1'b1, 4, 6, 1'b0, 1'b0, 1'b0);   step();
        beat(1'b1, -4, 6, 1'b0, 1'b0, 1'b0);  step();
        beat(1'b1, 2, 4, 1'b0, 1'b0, 1'b0);   step();
        beat(1'b1, -2, 4, 1'b0, 1'b0, 1'b0);  step();
        idle();
        for (int j = 4; j <= 9; j++) begin
            if (j == 5) begin
                checks++;
                if (s4_valid !== 1'b1 || s4_data !== 32'sd2 || s4_sat !== 1'b0 || out_data !== 32'sd24) begin
                    errors++;
                    $display("FAIL round_24: got s4=%0d raw=%0d expected 2 24", s4_data, out_data);
                end
            end
            if (j == 6) begin
                checks++;
                if (s4_data !== 32'(-1) || out_data !== 32'(-24)) begin
                    errors++;
                    $display("FAIL round_m24: got s4=%0d raw=%0d expected -1 -24", s4_data, out_data);
                end
            end
            if (j == 7) begin
                checks++;
                if (s4_data !== 32'sd1) begin
                    errors++;
                    $display("FAIL round_8: got %0d expected 1", s4_data);
                end
            end
            if (j == 8) begin
                checks++;
                if (s4_valid !== 1'b1 || s4_data !== 32'sd0 || out_data !== 32'(-8)) begin
                    errors++;
                    $display("FAIL round_m8: got v=%b s4=%0d raw=%0d expected 1 0 -8", s4_valid, s4_data, out_data);
                end
            end
            if (j < 9) step();
        end
    endtask

    task automatic test_ce_stall();
        beat(1'b1, 2, 3, 1'b1, 1'b1, 1'b0);
        step();
        beat(1'b1, 4, 5, 1'b1, 1'b0, 1'b0);
        step();
        ce = 1'b0;
        beat(1'b1, 100, 100, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || out_data !== 32'(-8)) begin
                errors++;
                $display("FAIL stall_hold k=%0d: got v=%b d=%0d expected 0 -8", k, out_valid, out_data);
            end
        end
        ce = 1'b1;
        beat(1'b1, -1, 6, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (out_valid !== (k == 5)) begin
                errors++;
                $display("FAIL stall_valid k=%0d: got %b expected %b", k, out_valid, (k == 5));
            end
            if (k < 5) step();
        end
        checks++;
        if (out_data !== 32'sd20) begin
            errors++;
            $display("FAIL stall_data: got %0d expected 20", out_data);
        end
        ce = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'sd20) begin
                errors++;
                $display("FAIL stall_valid_hold k=%0d: got v=%b d=%0d expected 1 20", k, out_valid, out_data);
            end
        end
        ce = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'sd20) begin
            errors++;
            $display("FAIL stall_release: got v=%b d=%0d expected 0 20", out_valid, out_data);
        end
    endtask

    task automatic test_mode_switch();
        beat(1'b1, 2, 3, 1'b1, 1'b1, 1'b0);    step();
        beat(1'b1, 10, 10, 1'b0, 1'b0, 1'b0);  step();
        beat(1'b1, 1, 1, 1'b1, 1'b0, 1'b1);    step();
        idle();
        for (int j = 3; j <= 8; j++) begin
            checks++;
            if (out_valid !== (j == 6 || j == 7)) begin
                errors++;
                $display("FAIL mode_valid j=%0d: got %b expected %b", j, out_valid, (j == 6 || j == 7));
            end
            if (j == 6) begin
                checks++;
                if (out_data !== 32'sd100) begin
                    errors++;
                    $display("FAIL mode_mul: got %0d expected 100", out_data);
                end
            end
            if (j == 7) begin
                checks++;
                if (out_data !== 32'sd101 || out_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL mode_cont: got %0d ovf=%b expected 101 0", out_data, out_ovf);
                end
            end
            if (j < 8) step();
        end
    endtask

    task automatic test_overflow();
        beat(1'b1, -32768, -4194304, 1'b1, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 1022; i++) begin
            beat(1'b1, -32768, -4194304, 1'b1, 1'b0, 1'b0);
            step();
        end
        beat(1'b1, -32768, -4194304, 1'b1, 1'b0, 1'b1);
        step();
        beat(1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        for (int k = 2; k <= 7; k++) begin
            if (k == 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'sh80000000 || out_sat !== 1'b1 || out_ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL ovf_sum: got v=%b d=%0d s=%b o=%b expected 1 -2147483648 1 1", out_valid, out_data, out_sat, out_ovf);
                end
                checks++;
                if (s4_ovf !== 1'b1 || s4_data !== 32'sh80000000) begin
                    errors++;
                    $display("FAIL ovf_sum_s4: got d=%0d o=%b expected -2147483648 1", s4_data, s4_ovf);
                end
            end
            if (k == 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'sd1 || out_sat !== 1'b0 || out_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_clear: got v=%b d=%0d s=%b o=%b expected 1 1 0 0", out_valid, out_data, out_sat, out_ovf);
                end
            end
            if (k < 7) step();
        end
    endtask

    task automatic test_reset_mid();
        beat(1'b1, 2, 3, 1'b1, 1'b1, 1'b0);
        step();
        beat(1'b1, 4, 5, 1'b1, 1'b0, 1'b0);
        step();
        idle();
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'sd0 || out_sat !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got v=%b d=%0d s=%b o=%b expected 0 0 0 0", out_valid, out_data, out_sat, out_ovf);
        end
        step(); step();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_flush k=%0d: got %b expected 0", k, out_valid);
            end
        end
        beat(1'b1, -1, 6, 1'b1, 1'b0, 1'b1);  step();
        beat(1'b1, 7, 7, 1'b1, 1'b1, 1'b1);   step();
        beat(1'b1, -1, 6, 1'b1, 1'b0, 1'b1);  step();
        idle();
        for (int j = 3; j <= 8; j++) begin
            checks++;
            if (out_valid !== (j >= 5 && j <= 7)) begin
                errors++;
                $display("FAIL post_reset_valid j=%0d: got %b expected %b", j, out_valid, (j >= 5 && j <= 7));
            end
            if (j == 5) begin
                checks++;
                if (out_data !== 32'(-6)) begin
                    errors++;
                    $display("FAIL post_reset_acc0: got %0d expected -6", out_data);
                end
            end
            if (j == 6) begin
                checks++;
                if (out_data !== 32'sd49) begin
                    errors++;
                    $display("FAIL post_reset_49: got %0d expected 49", out_data);
                end
            end
            if (j == 7) begin
                checks++;
                if (out_data !== 32'sd43) begin
                    errors++;
                    $display("FAIL post_reset_cont: got %0d expected 43", out_data);
                end
            end
            if (j < 8) step();
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_accumulate();
        test_saturation();
        test_rounding();
        test_ce_stall();
        test_mode_switch();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
